alu_operand_stage: RTL and testbench

- Registered ALU operand-select stage between register-file read and the ALU.
- Successor to the single 2:1 operand-B mux. Selects operand A (rs1 or PC) and operand B (rs2 or immediate).
- Resolves data hazards by forwarding from Num_Fwd later pipeline stages.
- Holds results in a 2-entry skid buffer with valid/ready handshakes on both sides.

---
 rtl/alu_operand_pkg.sv | 19 +
 rtl/operand_fwd_sel.sv | 37 +++
 rtl/alu_operand_stage.sv | 124 ++++++++++++
 tb/tb_alu_operand_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_pkg.sv
// Purpose: shared types and constants for the ALU operand-select stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: operand_entry_t (one buffered operand set), buffer depth, x0 index.
package alu_operand_pkg;

    // Width of the buffered operand fields; the stage's Data_Width defaults to this.
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 2;
    // Register x0 is hardwired to zero and must never take a forwarded value.
    localparam int ZERO_REG  = 0;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] store_data;
    } operand_entry_t;

endpackage

// File: rtl/operand_fwd_sel.sv
// Purpose: priority-select one source register value from the forwarding sources.
// Latency: combinational.
// Backpressure: none; pure datapath.
// Ports: addr/rf_data = register being read and its register-file value;
//        fwd_valid/fwd_addr/fwd_data = packed sources, index 0 in LSBs;
//        data = resolved value, hit = value came from a forwarding source.
module operand_fwd_sel
    import alu_operand_pkg::*;
#(
    parameter int Data_Width = DATA_W,
    parameter int Addr_Width = 5,
    parameter int Num_Fwd    = 2
) (
    input  logic [Addr_Width-1:0]         addr,
    input  logic [Data_Width-1:0]         rf_data,
    input  logic [Num_Fwd-1:0]            fwd_valid,
    input  logic [Num_Fwd*Addr_Width-1:0] fwd_addr,
    input  logic [Num_Fwd*Data_Width-1:0] fwd_data,
    output logic [Data_Width-1:0]         data,
    output logic                          hit
);

    always_comb begin
        data = rf_data;
        hit  = 1'b0;
        // Walk from the oldest source down so the youngest (index 0) match wins.
        for (int i = Num_Fwd - 1; i >= 0; i--) begin
            if (fwd_valid[i] &&
                (fwd_addr[i*Addr_Width +: Addr_Width] == addr) &&
                (addr != Addr_Width'(ZERO_REG))) begin
                data = fwd_data[i*Data_Width +: Data_Width];
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Purpose: resolve hazards by forwarding, select ALU operands, buffer them in a 2-entry FIFO.
// Latency: 1 cycle; a set accepted at edge N is presented in cycle N+1.
// Backpressure: in_ready = buffer not full, from registered state only (no out_ready path).
// Ports: in_valid/in_ready + rs*/pc/imm/ALUSrc* = upstream operand set;
//        fwd_* = forwarding sources; out_valid/out_ready + ALUOp1/ALUOp2/store_data = to ALU;
//        fwd_count = saturating count of register reads satisfied by forwarding.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int Data_Width = DATA_W,
    parameter int Addr_Width = 5,
    parameter int Num_Fwd    = 2,
    parameter int Cnt_Width  = 16    // must be >= 2 so one accept's increment fits
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [Addr_Width-1:0]         rs1_addr,
    input  logic [Addr_Width-1:0]         rs2_addr,
    input  logic [Data_Width-1:0]         rs1_data,
    input  logic [Data_Width-1:0]         rs2_data,
    input  logic [Data_Width-1:0]         pc,
    input  logic [Data_Width-1:0]         imm,
    input  logic                          ALUSrcA,
    input  logic                          ALUSrc,
    input  logic [Num_Fwd-1:0]            fwd_valid,
    input  logic [Num_Fwd*Addr_Width-1:0] fwd_addr,
    input  logic [Num_Fwd*Data_Width-1:0] fwd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Data_Width-1:0]         ALUOp1,
    output logic [Data_Width-1:0]         ALUOp2,
    output logic [Data_Width-1:0]         store_data,
    output logic [Cnt_Width-1:0]          fwd_count
);

    logic [Data_Width-1:0] rs1_fwd, rs2_fwd;
    logic                  rs1_hit, rs2_hit;

    operand_fwd_sel #(
        .Data_Width(Data_Width), .Addr_Width(Addr_Width), .Num_Fwd(Num_Fwd)
    ) u_rs1_sel (
        .addr(rs1_addr), .rf_data(rs1_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .data(rs1_fwd), .hit(rs1_hit)
    );

    operand_fwd_sel #(
        .Data_Width(Data_Width), .Addr_Width(Addr_Width), .Num_Fwd(Num_Fwd)
    ) u_rs2_sel (
        .addr(rs2_addr), .rf_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .data(rs2_fwd), .hit(rs2_hit)
    );

    // Operands are resolved now and frozen; buffered entries are never re-forwarded.
    operand_entry_t new_entry;
    always_comb begin
        new_entry            = '0;
        new_entry.op1        = ALUSrcA ? pc  : rs1_fwd;
        new_entry.op2        = ALUSrc  ? imm : rs2_fwd;
        new_entry.store_data = rs2_fwd;
    end

    // Two-entry FIFO: 1-bit head/tail pointers suffice for BUF_DEPTH == 2.
    operand_entry_t entry_q [BUF_DEPTH];
    logic           head_q, tail_q;
    logic [1:0]     count_q;
    logic           push, pop;

    assign in_ready  = (count_q != 2'(BUF_DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                entry_q[tail_q] <= new_entry;
                tail_q          <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ALUOp1     = entry_q[head_q].op1;
    assign ALUOp2     = entry_q[head_q].op2;
    assign store_data = entry_q[head_q].store_data;

    // rs2 counts as a forwarded read even when the immediate replaces it on ALUOp2.
    logic [1:0]           fwd_add;
    logic [Cnt_Width:0]   cnt_sum;
    logic [Cnt_Width-1:0] fwd_count_q;

    assign fwd_add = {1'b0, rs1_hit} + {1'b0, rs2_hit};
    assign cnt_sum = {1'b0, fwd_count_q} + {{(Cnt_Width-1){1'b0}}, fwd_add};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count_q <= '0;
        end else if (push) begin
            // Carry out of the sum means the counter would wrap: pin it at all-ones.
            fwd_count_q <= cnt_sum[Cnt_Width] ? '1 : cnt_sum[Cnt_Width-1:0];
        end
    end

    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, ALUSrcA, ALUSrc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, pc, imm;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        in_ready, out_valid;
    logic [31:0] ALUOp1, ALUOp2, store_data;
    logic [15:0] fwd_count;
    // Second instance with a 2-bit counter, driven by the same inputs.
    logic        sat_in_ready, sat_out_valid;
    logic [31:0] sat_op1, sat_op2, sat_store;
    logic [1:0]  sat_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUOp1(ALUOp1), .ALUOp2(ALUOp2), .store_data(store_data), .fwd_count(fwd_count)
    );

    alu_operand_stage #(.Cnt_Width(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .ALUOp1(sat_op1), .ALUOp2(sat_op2), .store_data(sat_store), .fwd_count(sat_count)
    );

    task automatic clear_inputs;
        in_valid = 0; out_ready = 1; ALUSrcA = 0; ALUSrc = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
        pc = 0; imm = 0; fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (ALUOp1 !== 32'h0 || ALUOp2 !== 32'h0) begin errors++; $display("FAIL reset_ops got %h/%h want 0/0", ALUOp1, ALUOp2); end
        checks++; if (store_data !== 32'h0) begin errors++; $display("FAIL reset_store got %h want 0", store_data); end
        checks++; if (fwd_count !== 16'h0) begin errors++; $display("FAIL reset_fwd_count got %h want 0", fwd_count); end
        #9 rst = 0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
        exp_cnt = 0;
    endtask

    task automatic test_no_hazard;
        in_valid = 1; rs1_addr = 3; rs1_data = 32'h10; rs2_addr = 4; rs2_data = 32'h20;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nohaz_valid got %b want 1", out_valid); end
        checks++; if (ALUOp1 !== 32'h10) begin errors++; $display("FAIL nohaz_op1 got %h want 10", ALUOp1); end
        checks++; if (ALUOp2 !== 32'h20) begin errors++; $display("FAIL nohaz_op2 got %h want 20", ALUOp2); end
        checks++; if (store_data !== 32'h20) begin errors++; $display("FAIL nohaz_store got %h want 20", store_data); end
        checks++; if (fwd_count !== exp_cnt) begin errors++; $display("FAIL nohaz_cnt got %h want %h", fwd_count, exp_cnt); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nohaz_drain got %b want 0", out_valid); end
    endtask

    task automatic test_priority_fwd;
        // Both sources match rs1=5: youngest (index 0) must win.
        in_valid = 1; rs1_addr = 5; rs1_data = 32'h55; rs2_addr = 6; rs2_data = 32'h66;
        fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
        step();
        exp_cnt = exp_cnt + 1;
        checks++; if (ALUOp1 !== 32'hAA) begin errors++; $display("FAIL prio_op1 got %h want aa", ALUOp1); end
        checks++; if (ALUOp2 !== 32'h66) begin errors++; $display("FAIL prio_op2 got %h want 66", ALUOp2); end
        checks++; if (fwd_count !== exp_cnt) begin errors++; $display("FAIL prio_cnt got %h want %h", fwd_count, exp_cnt); end
        // Only source 1 valid: its value is taken.
        fwd_valid = 2'b10;
        step();
        exp_cnt = exp_cnt + 1;
        checks++; if (ALUOp1 !== 32'hBB) begin errors++; $display("FAIL prio_src1 got %h want bb", ALUOp1); end
        // PC and immediate selected; rs2 forwarded value still reaches store_data and the count.
        ALUSrcA = 1; ALUSrc = 1; pc = 32'h1000; imm = 32'h1234;
        rs1_addr = 9; rs2_addr = 7; rs2_data = 32'h70;
        fwd_valid = 2'b10; fwd_addr = {5'd7, 5'd0}; fwd_data = {32'h77, 32'h0};
        step();
        in_valid = 0;
        exp_cnt = exp_cnt + 1;
        checks++; if (ALUOp1 !== 32'h1000) begin errors++; $display("FAIL sel_pc got %h want 1000", ALUOp1); end
        checks++; if (ALUOp2 !== 32'h1234) begin errors++; $display("FAIL sel_imm got %h want 1234", ALUOp2); end
        checks++; if (store_data !== 32'h77) begin errors++; $display("FAIL sel_store_fwd got %h want 77", store_data); end
        checks++; if (fwd_count !== exp_cnt) begin errors++; $display("FAIL sel_cnt got %h want %h", fwd_count, exp_cnt); end
        clear_inputs();
        step();
    endtask

    task automatic test_x0_guard;
        in_valid = 1; rs1_addr = 0; rs1_data = 0; rs2_addr = 0; rs2_data = 0;
        ALUSrc = 1; imm = 32'hFFFFFFFC;
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFF};
        step();
        in_valid = 0;
        checks++; if (ALUOp1 !== 32'h0) begin errors++; $display("FAIL x0_op1 got %h want 0", ALUOp1); end
        checks++; if (ALUOp2 !== 32'hFFFFFFFC) begin errors++; $display("FAIL x0_op2 got %h want fffffffc", ALUOp2); end
        checks++; if (store_data !== 32'h0) begin errors++; $display("FAIL x0_store got %h want 0", store_data); end
        checks++; if (fwd_count !== exp_cnt) begin errors++; $display("FAIL x0_cnt got %h want %h", fwd_count, exp_cnt); end
        clear_inputs();
        step();
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        in_valid = 1; rs1_data = 32'hA; rs2_data = 32'hA0;
        step();
        checks++; if (ALUOp1 !== 32'hA || in_ready !== 1'b1) begin errors++; $display("FAIL bp_a got op1 %h rdy %b want a 1", ALUOp1, in_ready); end
        rs1_data = 32'hB; rs2_data = 32'hB0;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got rdy %b want 0", in_ready); end
        checks++; if (ALUOp1 !== 32'hA) begin errors++; $display("FAIL bp_hold1 got %h want a", ALUOp1); end
        rs1_data = 32'hC; rs2_data = 32'hC0;
        step();
        checks++; if (ALUOp1 !== 32'hA || ALUOp2 !== 32'hA0 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold2 got %h %h rdy %b want a a0 0", ALUOp1, ALUOp2, in_ready); end
        out_ready = 1;
        step();  // pops A; C not taken this edge because the buffer was full
        checks++; if (ALUOp1 !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_b got %h v%b r%b want b 1 1", ALUOp1, out_valid, in_ready); end
        step();  // pops B, pushes C
        in_valid = 0;
        checks++; if (ALUOp1 !== 32'hC || ALUOp2 !== 32'hC0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_c got %h %h v%b want c c0 1", ALUOp1, ALUOp2, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
        checks++; if (fwd_count !== exp_cnt) begin errors++; $display("FAIL bp_cnt got %h want %h", fwd_count, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        out_ready = 1;
        in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            v = 32'h100 + 32'(k);
            rs1_data = v;
            step();
            checks++; if (ALUOp1 !== v || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_%0d got %h v%b r%b want %h 1 1", k, ALUOp1, out_valid, in_ready, v); end
        end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_sat;
        #2 rst = 1;
        #2 rst = 0;
        exp_cnt = 0;
        exp_sat = 0;
        step();
        in_valid = 1; out_ready = 1;
        rs1_addr = 1; rs2_addr = 2;
        fwd_valid = 2'b11; fwd_addr = {5'd2, 5'd1}; fwd_data = {32'h22, 32'h11};
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_cnt = exp_cnt + 2;
            exp_sat = (k == 1) ? 2'd2 : 2'd3;
            checks++; if (sat_count !== exp_sat) begin errors++; $display("FAIL sat_%0d got %0d want %0d", k, sat_count, exp_sat); end
        end
        in_valid = 0;
        checks++; if (fwd_count !== exp_cnt) begin errors++; $display("FAIL sat_wide got %0d want %0d", fwd_count, exp_cnt); end
        checks++; if (sat_op1 !== 32'h11 || sat_store !== 32'h22) begin errors++; $display("FAIL sat_data got %h %h want 11 22", sat_op1, sat_store); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_midflight;
        out_ready = 0; in_valid = 1;
        rs1_addr = 3; rs1_data = 32'h33;
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd3}; fwd_data = {32'h0, 32'hD3};
        step();
        step();
        in_valid = 0;
        checks++; if (in_ready !== 1'b0 || fwd_count === 16'h0) begin errors++; $display("FAIL mid_setup got rdy %b cnt %h want 0 nonzero", in_ready, fwd_count); end
        #2 rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
        checks++; if (fwd_count !== 16'h0 || ALUOp1 !== 32'h0) begin errors++; $display("FAIL mid_async_clear got %h %h want 0 0", fwd_count, ALUOp1); end
        @(posedge clk);
        #3 rst = 0;
        out_ready = 1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d got %b want 0", k, out_valid); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_priority_fwd();
        test_x0_guard();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
